// File: rtl/fact_share_arb_pkg.sv
// Shared types and helpers for the factorial-unit sharing arbiter.
// FACT_SHARE_ARB_STATS_EN is left undefined by default (grant/in-flight statistics off).
package fact_share_arb_pkg;

    localparam int INT_N = 16;
    typedef logic [INT_N-1:0] int_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fact_share_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight transaction.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fact_share_tag_fifo
    import fact_share_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [TAG_W-1:0]       din,
    output logic [TAG_W-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fact_share_arb.sv
// Round-robin arbiter sharing one in-order sync compute unit between N requesters.
// Define FACT_SHARE_ARB_STATS_EN to add per-requester grant counters and an in-flight high-water mark.
module fact_share_arb
    import fact_share_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int W     = INT_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*W-1:0]         req_data,
    output logic [N-1:0]           rsp_valid,
    input  logic [N-1:0]           rsp_ready,
    output logic [N*W-1:0]         rsp_data,
    output logic                   u_in_valid,
    input  logic                   u_in_ready,
    output logic [W-1:0]           u_in0,
    input  logic                   u_out_valid,
    output logic                   u_out_ready,
    input  logic [W-1:0]           u_out0
`ifdef FACT_SHARE_ARB_STATS_EN
    ,
    output logic [N*16-1:0]        grant_cnt,
    output logic [clog2(DEPTH):0]  max_inflight
`endif
);

    localparam int TAG_W = clog2(N);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] cand;
    logic [TAG_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             can_push;
    logic             fire;
    logic             pop;

    // First valid requester after the last granted one, wrapping mod N.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [N-1:0] valid,
                                                 input logic [TAG_W-1:0] ptr);
        logic [TAG_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = TAG_W'(idx);
            end
        end
        return pick;
    endfunction

    assign cand        = rr_pick(req_valid, rr_ptr);
    assign u_out_ready = rsp_ready[head] && !fifo_empty;
    assign pop         = u_out_valid && u_out_ready;
    assign can_push    = !fifo_full || pop;
    assign u_in_valid  = (|req_valid) && can_push && !rst;
    assign u_in0       = req_data[cand*W +: W];
    assign fire        = u_in_valid && u_in_ready;
    assign rsp_data    = {N{u_out0}};

    always_comb begin
        req_ready = '0;
        if (fire) req_ready[cand] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (u_out_valid && !fifo_empty) rsp_valid[head] = 1'b1;
    end

    // Priority only moves on an actual issue, never on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr <= TAG_W'(N - 1);
        else if (fire) rr_ptr <= cand;
    end

    fact_share_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .pop   (pop),
        .din   (cand),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef FACT_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt    <= '0;
            max_inflight <= '0;
        end else begin
            if (fire && grant_cnt[cand*16 +: 16] != 16'hFFFF)
                grant_cnt[cand*16 +: 16] <= grant_cnt[cand*16 +: 16] + 16'd1;
            if (fifo_count > max_inflight) max_inflight <= fifo_count;
        end
    end
`else
    logic unused_count;
    assign unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_fact_share_arb.sv
// Randomized and directed bench for fact_share_arb with an in-order factorial unit model.
// Expected grants/results come from a queue-based model of the arbitration rules.
module tb_fact_share_arb;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [N*W-1:0]   rsp_data;
    logic             u_in_valid;
    logic             u_in_ready;
    logic [W-1:0]     u_in0;
    logic             u_out_valid;
    logic             u_out_ready;
    logic [W-1:0]     u_out0;
`ifdef FACT_SHARE_ARB_STATS_EN
    logic [N*16-1:0]        grant_cnt;
    logic [$clog2(DEPTH):0] max_inflight;
`endif

    always #5 clk = ~clk;

    fact_share_arb #(.N(N), .DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .u_in_valid   (u_in_valid),
        .u_in_ready   (u_in_ready),
        .u_in0        (u_in0),
        .u_out_valid  (u_out_valid),
        .u_out_ready  (u_out_ready),
        .u_out0       (u_out0)
`ifdef FACT_SHARE_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .max_inflight (max_inflight)
`endif
    );

    typedef struct { int lane; logic [W-1:0] val; } exp_t;
    typedef struct { logic [W-1:0] val; int t; } unit_t;

    exp_t        exp_q[$];
    unit_t       uq[$];
    int          obs_order[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          last_grant;
    int          cyc = 0;
    int          lane_left[N];
    logic [W-1:0] lane_op[N];
    int          rx_cnt[N];
    logic [W-1:0] rx_last[N];
    int          rv_seen[N];
    int          issue_cnt[N];
    int          max_fl;
    bit          rand_load, rand_rsp, rand_uir;
    logic [N-1:0] rsp_mask;
    logic        last_uiv;

    function automatic logic [W-1:0] fact(input logic [W-1:0] n);
        logic [W-1:0] r;
        r = 1;
        for (int k = 2; k <= int'(n); k++) r = r * W'(k);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic clr_obs();
        obs_order.delete();
        for (int i = 0; i < N; i++) begin
            rx_cnt[i]  = 0;
            rv_seen[i] = 0;
            rx_last[i] = '0;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) if (lane_left[i] > 0) p = 1'b1;
        return p;
    endfunction

    task automatic tick(input bit do_rst);
        int           cand;
        bit           found, any, full_m, pop_m, exp_iv, fire_m;
        logic [N-1:0] exp_rr, exp_rv;
        exp_t         e;
        unit_t        u;
        @(negedge clk);
        rst = do_rst;
        if (do_rst) uq.delete();
        for (int i = 0; i < N; i++) begin
            if (rand_load && lane_left[i] == 0 && $urandom_range(0, 2) == 0) begin
                lane_left[i] = 1;
                lane_op[i]   = W'($urandom_range(0, 8));
            end
            req_valid[i]       = (lane_left[i] > 0);
            req_data[i*W +: W] = lane_op[i];
        end
        rsp_ready   = rsp_mask & (rand_rsp ? N'($urandom_range(0, (1 << N) - 1)) : {N{1'b1}});
        u_in_ready  = rand_uir ? ($urandom_range(0, 3) != 0) : 1'b1;
        u_out_valid = (uq.size() > 0) && (uq[0].t <= cyc);
        u_out0      = (uq.size() > 0) ? uq[0].val : '0;
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) obs_order.push_back(i);
            if (rsp_valid[i]) rv_seen[i]++;
            if (rsp_valid[i] && rsp_ready[i]) begin
                rx_cnt[i]++;
                rx_last[i] = rsp_data[i*W +: W];
            end
        end
        last_uiv = u_in_valid;

        any   = |req_valid;
        cand  = 0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && lane_left[(last_grant + k) % N] > 0) begin
                found = 1'b1;
                cand  = (last_grant + k) % N;
            end
        end
        full_m = exp_q.size() >= DEPTH;
        pop_m  = u_out_valid && exp_q.size() > 0 && rsp_ready[exp_q[0].lane];
        exp_iv = !do_rst && any && (!full_m || pop_m);
        fire_m = exp_iv && u_in_ready;
        exp_rr = fire_m ? (N'(1) << cand) : '0;
        exp_rv = (u_out_valid && exp_q.size() > 0) ? (N'(1) << exp_q[0].lane) : '0;

        check("u_in_valid", u_in_valid, exp_iv);
        if (exp_iv) check("u_in0", u_in0, lane_op[cand]);
        check("req_ready", req_ready, exp_rr);
        check("rsp_valid", rsp_valid, exp_rv);
        check("u_out_ready", u_out_ready, exp_q.size() > 0 && rsp_ready[exp_q[0].lane]);
        if (u_out_valid) check("unit_orphan", exp_q.size() > 0, 1);
        if (pop_m) begin
            check("rsp_data", rsp_data[exp_q[0].lane*W +: W], exp_q[0].val);
            void'(exp_q.pop_front());
        end
        if (fire_m) begin
            e.lane = cand;
            e.val  = fact(lane_op[cand]);
            exp_q.push_back(e);
            last_grant = cand;
            issue_cnt[cand]++;
            lane_left[cand]--;
        end
        if (do_rst) begin
            exp_q.delete();
            last_grant = N - 1;
            max_fl     = 0;
            for (int i = 0; i < N; i++) issue_cnt[i] = 0;
        end
        if (exp_q.size() > max_fl) max_fl = exp_q.size();

        if (u_out_valid && u_out_ready) void'(uq.pop_front());
        if (u_in_valid && u_in_ready) begin
            u.val = fact(u_in0);
            u.t   = cyc + int'($urandom_range(1, 3));
            if (uq.size() > 0 && uq[uq.size()-1].t > u.t) u.t = uq[uq.size()-1].t;
            uq.push_back(u);
        end
        cyc++;
    endtask

    task automatic drain(input int bound);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || pending()) && c < bound) begin
            tick(1'b0);
            c++;
        end
        check("drain_done", exp_q.size() == 0 && !pending(), 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_data = '0; rsp_ready = '0;
        u_in_ready = 1'b0; u_out_valid = 1'b0; u_out0 = '0;
        rand_load = 1'b0; rand_rsp = 1'b0; rand_uir = 1'b0;
        rsp_mask = '1; last_grant = N - 1; max_fl = 0;
        for (int i = 0; i < N; i++) begin
            lane_left[i] = 0; lane_op[i] = '0; issue_cnt[i] = 0;
        end
        clr_obs();
        tick(1'b1);
        tick(1'b1);

        // single requester: 5 then 3
        lane_op[0] = 16'd5; lane_left[0] = 1;
        drain(40);
        lane_op[0] = 16'd3; lane_left[0] = 1;
        drain(40);
        check("s1_rx_cnt0", rx_cnt[0], 2);
        check("s1_last0", rx_last[0], 16'd6);
        check("s1_rv_other", rv_seen[1] + rv_seen[2] + rv_seen[3], 0);

        // all four at once from reset priority
        tick(1'b1);
        clr_obs();
        for (int i = 0; i < N; i++) begin
            lane_op[i] = W'(i + 3); lane_left[i] = 1;
        end
        drain(60);
        for (int i = 0; i < N; i++) check("s2_order", obs_order[i], i);
        check("s2_lane0", rx_last[0], 16'd6);
        check("s2_lane1", rx_last[1], 16'd24);
        check("s2_lane2", rx_last[2], 16'd120);
        check("s2_lane3", rx_last[3], 16'd720);

        // fairness between lanes 0 and 2
        clr_obs();
        lane_op[0] = 16'd4; lane_left[0] = 6;
        lane_op[2] = 16'd4; lane_left[2] = 6;
        drain(120);
        for (int k = 0; k < 12; k++) check("s3_alt", obs_order[k], (k % 2) * 2);
        check("s3_rx0", rx_cnt[0], 6);
        check("s3_rx2", rx_cnt[2], 6);
        check("s3_val2", rx_last[2], 16'd24);

        // backpressure on lane 1 fills the tag FIFO
        clr_obs();
        rsp_mask = 4'b1101;
        lane_op[1] = 16'd3; lane_left[1] = 8;
        for (int k = 0; k < 20; k++) tick(1'b0);
        check("s4_issues", obs_order.size(), DEPTH);
        check("s4_stall", last_uiv, 1'b0);
        check("s4_held", rv_seen[1] > 0 && rx_cnt[1] == 0, 1);
        rsp_mask = '1;
        tick(1'b0);
        check("s4_push_pop", obs_order.size(), DEPTH + 1);
        drain(80);
        check("s4_rx1", rx_cnt[1], 8);

        // reset with three tags in flight
        clr_obs();
        rsp_mask = '0;
        for (int i = 0; i < 3; i++) begin
            lane_op[i] = 16'd7; lane_left[i] = 1;
        end
        for (int k = 0; k < 6; k++) tick(1'b0);
        check("s5_inflight", obs_order.size(), 3);
        tick(1'b1);
        rsp_mask = '1;
        lane_op[3] = 16'd4; lane_left[3] = 1;
        drain(40);
        check("s5_lane3", rx_last[3], 16'd24);
        check("s5_dropped", rx_cnt[0] + rx_cnt[1] + rx_cnt[2], 0);

        // randomized traffic
        tick(1'b1);
        rand_load = 1'b1; rand_rsp = 1'b1; rand_uir = 1'b1;
        for (int k = 0; k < 2000; k++) tick(1'b0);
        rand_load = 1'b0; rand_rsp = 1'b0;
        drain(200);
        tick(1'b0);
        tick(1'b0);
`ifdef FACT_SHARE_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*16 +: 16], issue_cnt[i]);
        check("max_inflight", max_inflight, max_fl);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
